// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART_TX scheduler: FSM encoding, byte width,
// Busy timeout and the helper that sizes the timeout counter.
package uart_tx_sched_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_BUSY_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SEND    = ST_SEND,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } sched_state_t;

  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  localparam int TIMEOUT_CNT_W = cnt_width(DEF_BUSY_TIMEOUT);

endpackage

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; ptr remembers the last winner so that
// on a tie the other requester is served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to 1 so that req0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      ptr <= grant[1];
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART_TX between two requesters: round-robin grant, 1- or 2-byte
// messages sent high byte first, parity config latched per message.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [2*DATA_WIDTH-1:0] req0_data,
  input  logic                    req0_two,
  output logic                    req0_ack,
  output logic                    req0_done,
  input  logic                    req1_valid,
  input  logic [2*DATA_WIDTH-1:0] req1_data,
  input  logic                    req1_two,
  output logic                    req1_ack,
  output logic                    req1_done,
  input  logic                    cfg_par_en,
  input  logic                    cfg_par_type,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_data_valid,
  output logic                    tx_par_en,
  output logic                    tx_par_type,
  input  logic                    tx_busy,
  output logic                    sched_err
);

  localparam int CW = cnt_width(BUSY_TIMEOUT);

  sched_state_t            state;
  logic [CW-1:0]           cnt;
  logic [2*DATA_WIDTH-1:0] msg_data;
  logic                    msg_two;
  logic                    msg_id;
  logic                    first_byte;

  logic [1:0]              grant;
  logic                    arb_update;
  logic                    sel_id;
  logic [2*DATA_WIDTH-1:0] sel_data;
  logic                    sel_two;

  assign arb_update = (state == IDLE) && !tx_busy;
  assign sel_id     = grant[1];
  assign sel_data   = sel_id ? req1_data : req0_data;
  assign sel_two    = sel_id ? req1_two  : req0_two;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .update (arb_update),
    .grant  (grant)
  );

  // The error is raised one count early so the pulse lands in the cycle the
  // counter reads BUSY_TIMEOUT-1, i.e. BUSY_TIMEOUT cycles after Data_Valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      msg_data      <= '0;
      msg_two       <= 1'b0;
      msg_id        <= 1'b0;
      first_byte    <= 1'b0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_type   <= 1'b0;
      req0_ack      <= 1'b0;
      req1_ack      <= 1'b0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      sched_err     <= 1'b0;
    end else begin
      tx_data_valid <= 1'b0;
      req0_ack      <= 1'b0;
      req1_ack      <= 1'b0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      sched_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && (grant != 2'b00)) begin
            msg_data      <= sel_data;
            msg_two       <= sel_two;
            msg_id        <= sel_id;
            first_byte    <= 1'b1;
            tx_par_en     <= cfg_par_en;
            tx_par_type   <= cfg_par_type;
            tx_p_data     <= sel_two ? sel_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : sel_data[DATA_WIDTH-1:0];
            tx_data_valid <= 1'b1;
            req0_ack      <= grant[0];
            req1_ack      <= grant[1];
            state         <= SEND;
          end
        end
        SEND: begin
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(BUSY_TIMEOUT - 2)) begin
              sched_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (msg_two && first_byte) begin
              first_byte    <= 1'b0;
              tx_p_data     <= msg_data[DATA_WIDTH-1:0];
              tx_data_valid <= 1'b1;
              state         <= SEND;
            end else begin
              req0_done <= !msg_id;
              req1_done <= msg_id;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a 1-cycle-per-bit UART_TX model supplies Busy,
// and scoreboard queues hold the expected bytes, ack ids and done ids.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_two = 1'b0, req1_two = 1'b0;
  logic        req0_ack, req0_done, req1_ack, req1_done;
  logic        cfg_par_en = 1'b0, cfg_par_type = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid, tx_par_en, tx_par_type, sched_err;
  logic        tx_busy = 1'b0;
  logic        stuck = 1'b0;
  logic [10:0] sh = '0;
  int          left = 0;
  logic        serial;

  int tests = 0;
  int failed = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       pe;
    logic       pt;
  } exp_byte_t;

  exp_byte_t byte_q[$];
  int        ack_q[$];
  int        done_q[$];

  always #5 clk = ~clk;

  uart_tx_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_two      (req0_two),
    .req0_ack      (req0_ack),
    .req0_done     (req0_done),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_two      (req1_two),
    .req1_ack      (req1_ack),
    .req1_done     (req1_done),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_type  (cfg_par_type),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .tx_par_en     (tx_par_en),
    .tx_par_type   (tx_par_type),
    .tx_busy       (tx_busy),
    .sched_err     (sched_err)
  );

  // Serial frame in transmission order: bit 0 = start, data LSB first, optional parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic pe, input logic pt);
    logic p;
    p = pt ? ~^b : ^b;
    return pe ? {1'b1, p, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART_TX stand-in: Busy rises the cycle after Data_Valid and stays up for one cycle per bit.
  assign serial = sh[0];
  always @(posedge clk) begin
    if (stuck) begin
      tx_busy <= 1'b0;
      left    <= 0;
    end else if (left == 0 && tx_data_valid) begin
      tx_busy <= 1'b1;
      sh      <= frame_of(tx_p_data, tx_par_en, tx_par_type);
      left    <= tx_par_en ? 11 : 10;
    end else if (left > 0) begin
      sh   <= sh >> 1;
      left <= left - 1;
      if (left == 1) tx_busy <= 1'b0;
    end
  end

  logic [10:0] cap = '0, exp_frame = '0;
  int          cidx = 0, exp_len = 0;
  logic        prev_busy = 1'b0, prev_dv = 1'b0, frame_pending = 1'b0;

  // Monitor: pops the scoreboard whenever the DUT emits a byte, ack or done.
  always @(negedge clk) begin
    exp_byte_t e;
    if (prev_busy && !tx_busy && frame_pending) begin
      checkOutput("frame_bits", cap, exp_frame);
      checkOutput("frame_len", cidx, exp_len);
      frame_pending = 1'b0;
    end
    if (tx_busy && cidx < 11) begin
      cap[cidx] = serial;
      cidx++;
    end
    if (tx_data_valid) begin
      checkOutput("dv_while_busy", tx_busy, 0);
      checkOutput("dv_pulse_width", prev_dv, 0);
      checkOutput("byte_expected", byte_q.size() != 0, 1);
      if (byte_q.size() != 0) begin
        e = byte_q.pop_front();
        checkOutput("tx_p_data", tx_p_data, e.b);
        checkOutput("tx_par_en", tx_par_en, e.pe);
        checkOutput("tx_par_type", tx_par_type, e.pt);
        exp_frame     = frame_of(e.b, e.pe, e.pt);
        exp_len       = e.pe ? 11 : 10;
        cap           = '0;
        cidx          = 0;
        frame_pending = 1'b1;
      end
    end
    if (req0_ack || req1_ack) begin
      checkOutput("ack_onehot", req0_ack & req1_ack, 0);
      checkOutput("ack_expected", ack_q.size() != 0, 1);
      if (ack_q.size() != 0) checkOutput("ack_id", req1_ack, ack_q.pop_front());
    end
    if (req0_done || req1_done) begin
      checkOutput("done_onehot", req0_done & req1_done, 0);
      checkOutput("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) checkOutput("done_id", req1_done, done_q.pop_front());
    end
    prev_dv   = tx_data_valid;
    prev_busy = tx_busy;
  end

  task automatic applyStimulus(input int id, input logic [15:0] data, input logic two,
                               input logic pe, input logic pt, input logic want_done);
    cfg_par_en   = pe;
    cfg_par_type = pt;
    if (two) byte_q.push_back({data[15:8], pe, pt});
    byte_q.push_back({data[7:0], pe, pt});
    ack_q.push_back(id);
    if (want_done) done_q.push_back(id);
    if (id == 0) begin
      req0_data = data; req0_two = two; req0_valid = 1'b1;
    end else begin
      req1_data = data; req1_two = two; req1_valid = 1'b1;
    end
  endtask

  // sel: 0 any ack, 1 any done, 2 sched_err, 3 Busy low, 4 Busy high
  task automatic wait_for(input string tag, input int sel, input int limit, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = req0_ack | req1_ack;
        1:       hit = req0_done | req1_done;
        2:       hit = sched_err;
        3:       hit = !tx_busy;
        4:       hit = tx_busy;
        default: hit = 1'b1;
      endcase
    end
    if (!hit) checkOutput({tag, "_timeout"}, hit, 1);
  endtask

  initial begin
    int n;
    int acks_during;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {tx_p_data, tx_data_valid, tx_par_en, tx_par_type,
                 req0_ack, req0_done, req1_ack, req1_done, sched_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: single byte from req0");
    applyStimulus(0, 16'h00C7, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_for("t1_ack", 0, 5, n);
    checkOutput("t1_ack_latency", n, 1);
    checkOutput("t1_dv_with_ack", tx_data_valid, 1);
    req0_valid = 1'b0;
    checkOutput("t1_par_en", tx_par_en, 0);
    wait_for("t1_done", 1, 40, n);
    @(negedge clk);

    $display("[TB] test 2: two bytes from req1, even parity");
    applyStimulus(1, 16'hA2B4, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_for("t2_ack", 0, 5, n);
    req1_valid = 1'b0;
    wait_for("t2_done", 1, 60, n);
    @(negedge clk);

    $display("[TB] test 3: both requesters held for four messages");
    applyStimulus(0, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_for("t3_ack", 0, 10, n);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      wait_for("t3_done", 1, 40, n);
    end
    @(negedge clk);

    $display("[TB] test 4: Busy stuck low");
    stuck = 1'b1;
    applyStimulus(0, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_for("t4_ack", 0, 5, n);
    req0_valid = 1'b0;
    wait_for("t4_err", 2, 40, n);
    checkOutput("t4_err_cycle", n, 16);
    @(negedge clk);
    checkOutput("t4_err_pulse", sched_err, 0);
    stuck = 1'b0;
    applyStimulus(1, 16'h0066, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_for("t4_regrant", 0, 5, n);
    checkOutput("t4_regrant_latency", n, 1);
    req1_valid = 1'b0;
    wait_for("t4_done", 1, 40, n);
    @(negedge clk);

    $display("[TB] test 5: reset during WAIT_LO");
    applyStimulus(0, 16'h00D5, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_for("t5_ack", 0, 5, n);
    req0_valid = 1'b0;
    wait_for("t5_busy", 4, 10, n);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_outputs",
                {tx_p_data, tx_data_valid, tx_par_en, tx_par_type,
                 req0_ack, req0_done, req1_ack, req1_done, sched_err}, 0);
    checkOutput("t5_busy_still_high", tx_busy, 1);
    rst = 1'b0;
    applyStimulus(0, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b1);
    acks_during = 0;
    n = 0;
    while (tx_busy && n < 40) begin
      @(negedge clk);
      if (tx_busy && (req0_ack || req1_ack)) acks_during++;
      n++;
    end
    checkOutput("t5_no_ack_while_busy", acks_during, 0);
    wait_for("t5_ack2", 0, 5, n);
    req0_valid = 1'b0;
    wait_for("t5_done", 1, 40, n);
    @(negedge clk);

    $display("[TB] test 6: parity type changed mid-message");
    applyStimulus(0, 16'h2727, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_for("t6_ack", 0, 5, n);
    req0_valid   = 1'b0;
    cfg_par_type = 1'b1;
    wait_for("t6_busy_fall", 3, 20, n);
    wait_for("t6_busy_rise2", 4, 10, n);
    checkOutput("t6_par_type_hold", tx_par_type, 0);
    wait_for("t6_done", 1, 40, n);
    repeat (3) @(negedge clk);

    checkOutput("sb_bytes_left", byte_q.size(), 0);
    checkOutput("sb_acks_left", ack_q.size(), 0);
    checkOutput("sb_dones_left", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
